apb_priority_intc: RTL

Parametrised, APB-programmable priority interrupt controller sitting between up to 32 peripheral interrupt lines and the processor. Per-source priority, enable and level/edge mode registers are written over APB. Requests are latched into a pending register and arbitrated by priority. A single winning ID is presented to the processor and held until the processor returns a serviced handshake.

---
 rtl/intc_pkg.sv | 20 ++
 rtl/apb_priority_intc_if.sv | 17 +
 rtl/intc_prio_arbiter.sv | 41 ++++
 rtl/apb_priority_intc.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// intc_pkg: shared constants and types for apb_priority_intc.
//   - APB word addresses of the register map
//   - APB data width
//   - grant FSM state encoding
package intc_pkg;

  localparam int APB_DATA_WIDTH = 32;

  localparam logic [7:0] ADDR_PRIO_BASE = 8'h00;
  localparam logic [7:0] ADDR_ENABLE    = 8'h40;
  localparam logic [7:0] ADDR_MODE      = 8'h41;
  localparam logic [7:0] ADDR_PENDING   = 8'h42;
  localparam logic [7:0] ADDR_STATUS    = 8'h43;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } grant_state_e;

endpackage

// File: rtl/apb_priority_intc_if.sv
// apb_priority_intc_if: APB slave bus bundle for the interrupt controller.
//   psel/penable/pwrite/paddr/pwdata : master -> slave
//   prdata/pready                    : slave  -> master
interface apb_priority_intc_if;
  logic                                psel;
  logic                                penable;
  logic                                pwrite;
  logic [7:0]                          paddr;
  logic [intc_pkg::APB_DATA_WIDTH-1:0] pwdata;
  logic [intc_pkg::APB_DATA_WIDTH-1:0] prdata;
  logic                                pready;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready);
endinterface

// File: rtl/intc_prio_arbiter.sv
// intc_prio_arbiter: combinational max-priority selector.
//   i_cand  : candidate vector (already qualified by pending/enable/prio!=0)
//   i_prio  : packed per-source priority array
//   o_id    : winning source index (highest priority, lowest index on ties)
//   o_prio  : priority of the winner
//   o_valid : at least one candidate present
module intc_prio_arbiter #(
  parameter int NO_OF_PERIPHERALS = 16,
  parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS),
  parameter int PRIO_WIDTH        = 4
) (
  input  logic [NO_OF_PERIPHERALS-1:0]                 i_cand,
  input  logic [NO_OF_PERIPHERALS-1:0][PRIO_WIDTH-1:0] i_prio,
  output logic [WIDTH-1:0]                             o_id,
  output logic [PRIO_WIDTH-1:0]                        o_prio,
  output logic                                         o_valid
);

  logic [WIDTH-1:0]      w_id;
  logic [PRIO_WIDTH-1:0] w_prio;
  logic                  w_vld;

  // Ascending scan with strict '>' keeps the lowest index on equal priority.
  always_comb begin
    w_id   = '0;
    w_prio = '0;
    w_vld  = 1'b0;
    for (int i = 0; i < NO_OF_PERIPHERALS; i++) begin
      if (i_cand[i] && (!w_vld || (i_prio[i] > w_prio))) begin
        w_vld  = 1'b1;
        w_id   = WIDTH'(i);
        w_prio = i_prio[i];
      end
    end
  end

  assign o_id    = w_id;
  assign o_prio  = w_prio;
  assign o_valid = w_vld;

endmodule

// File: rtl/apb_priority_intc.sv
// apb_priority_intc: APB-programmable priority interrupt controller.
//   pclk/preset             : clock, synchronous active-high reset
//   apb (slave modport)     : register access, zero wait states
//   interrupt_active        : raw peripheral requests
//   interrupt_to_be_service : granted source ID (registered)
//   interrupt_valid         : grant valid (registered)
//   interrupt_serviced      : one-cycle completion pulse from the CPU
// Optional build macro INTC_PREEMPT_EN: a strictly higher-priority candidate
// replaces the current grant while valid stays high.
module apb_priority_intc
  import intc_pkg::*;
#(
  parameter int NO_OF_PERIPHERALS = 16,
  parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS),
  parameter int PRIO_WIDTH        = 4
) (
  input  logic                         pclk,
  input  logic                         preset,
  apb_priority_intc_if.slave           apb,
  input  logic [NO_OF_PERIPHERALS-1:0] interrupt_active,
  output logic [WIDTH-1:0]             interrupt_to_be_service,
  output logic                         interrupt_valid,
  input  logic                         interrupt_serviced
);

  localparam int N = NO_OF_PERIPHERALS;

  logic [N-1:0][PRIO_WIDTH-1:0] r_prio;
  logic [N-1:0]                 r_enable;
  logic [N-1:0]                 r_mode;
  logic [N-1:0]                 r_pending;
  logic [N-1:0]                 r_sample;
  grant_state_e                 r_state, w_state_nxt;
  logic [WIDTH-1:0]             r_id, w_id_nxt;
  logic                         r_valid, w_valid_nxt;

  logic                         w_access, w_wr;
  logic [N-1:0]                 w_set, w_clr_apb, w_clr_svc, w_cand;
  logic [WIDTH-1:0]             w_win_id;
  logic [PRIO_WIDTH-1:0]        w_win_prio;
  logic                         w_win_vld;
  logic                         w_svc;
  logic [APB_DATA_WIDTH-1:0]    w_rdata;
  logic                         w_unused;

  assign w_access   = apb.psel & apb.penable;
  assign w_wr       = w_access & apb.pwrite;
  assign apb.pready = w_access;
  assign w_svc      = (r_state == ST_GRANT) & interrupt_serviced;
  assign w_unused   = ^{apb.pwdata, w_win_prio};

  // ---------------- configuration registers ----------------
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_prio   <= '0;
      r_enable <= '0;
      r_mode   <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < N; i++)
        if (apb.paddr == 8'(ADDR_PRIO_BASE + i))
          r_prio[i] <= apb.pwdata[PRIO_WIDTH-1:0];
      if (apb.paddr == ADDR_ENABLE) r_enable <= apb.pwdata[N-1:0];
      if (apb.paddr == ADDR_MODE)   r_mode   <= apb.pwdata[N-1:0];
    end
  end

  // ---------------- pending capture ----------------
  // Level sources set every active cycle; edge sources only on 0->1 of the
  // registered sample. Sets are OR-ed after clears so a same-cycle set wins.
  assign w_set     = interrupt_active & (~r_mode | ~r_sample);
  assign w_clr_apb = (w_wr && apb.paddr == ADDR_PENDING) ? apb.pwdata[N-1:0] : '0;
  assign w_clr_svc = w_svc ? (N'(1) << r_id) : '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_pending <= '0;
      r_sample  <= '0;
    end else begin
      r_pending <= (r_pending & ~(w_clr_apb | w_clr_svc)) | w_set;
      r_sample  <= interrupt_active;
    end
  end

  // ---------------- arbitration ----------------
  always_comb begin
    w_cand = '0;
    for (int i = 0; i < N; i++)
      w_cand[i] = r_pending[i] & r_enable[i] & (r_prio[i] != '0);
  end

  intc_prio_arbiter #(
    .NO_OF_PERIPHERALS (N),
    .WIDTH             (WIDTH),
    .PRIO_WIDTH        (PRIO_WIDTH)
  ) u_arb (
    .i_cand  (w_cand),
    .i_prio  (r_prio),
    .o_id    (w_win_id),
    .o_prio  (w_win_prio),
    .o_valid (w_win_vld)
  );

  // ---------------- grant FSM ----------------
  always_ff @(posedge pclk) begin
    if (preset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_win_vld) w_state_nxt = ST_GRANT;
      ST_GRANT: if (interrupt_serviced) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_id_nxt    = r_id;
    w_valid_nxt = r_valid;
    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = w_win_vld;
        if (w_win_vld) w_id_nxt = w_win_id;
      end
      ST_GRANT: begin
        if (interrupt_serviced) w_valid_nxt = 1'b0;
`ifdef INTC_PREEMPT_EN
        else if (w_win_vld && (w_win_prio > r_prio[r_id])) w_id_nxt = w_win_id;
`endif
      end
      default: w_valid_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_id    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_id    <= w_id_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign interrupt_to_be_service = r_id;
  assign interrupt_valid         = r_valid;

  // ---------------- read mux (combinational, access phase only) ----------------
  always_comb begin
    w_rdata = '0;
    if (w_access) begin
      for (int i = 0; i < N; i++)
        if (apb.paddr == 8'(ADDR_PRIO_BASE + i)) w_rdata[PRIO_WIDTH-1:0] = r_prio[i];
      if (apb.paddr == ADDR_ENABLE)  w_rdata[N-1:0] = r_enable;
      if (apb.paddr == ADDR_MODE)    w_rdata[N-1:0] = r_mode;
      if (apb.paddr == ADDR_PENDING) w_rdata[N-1:0] = r_pending;
      if (apb.paddr == ADDR_STATUS) begin
        w_rdata[APB_DATA_WIDTH-1] = r_valid;
        w_rdata[WIDTH-1:0]        = r_id;
      end
    end
  end

  assign apb.prdata = w_rdata;

endmodule
